tdm_demux8: RTL and testbench



---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_slot_ctr.sv | 52 +++++
 rtl/tdm_demux8.sv | 141 ++++++++++++++
 tb/tb_tdm_demux8.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM receive path.
//   tdm_state_t   : frame-alignment state (HUNT = searching for slot 0,
//                   LOCKED = aligned and assembling frames)
//   TDM_LANES_DEF : default number of lanes per frame
// -----------------------------------------------------------------------------
package tdm_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_t;

   localparam int TDM_LANES_DEF = 8;

endpackage : tdm_pkg

// File: rtl/tdm_slot_ctr.sv
// -----------------------------------------------------------------------------
// tdm_slot_ctr
// Slot index counter for the TDM demultiplexer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to slot 0 (highest priority)
//   load1      : force slot to 1 (a slot-0 beat has just been taken)
//   inc        : advance to the next slot (wraps at LANES-1 -> 0)
//   slot       : registered slot index expected for the next beat
//   is_last    : slot currently points at the last lane
// -----------------------------------------------------------------------------
module tdm_slot_ctr
   import tdm_pkg::*;
#(
   parameter int LANES  = TDM_LANES_DEF,
   localparam int SLOT_W = $clog2(LANES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load1,
   input  logic              inc,
   output logic [SLOT_W-1:0] slot,
   output logic              is_last
);

   logic [SLOT_W-1:0] slot_q;
   logic [SLOT_W-1:0] slot_d;

   // LANES is a power of two, so the natural SLOT_W-bit rollover is the wrap.
   always_comb begin
      slot_d = slot_q;
      if (clr) begin
         slot_d = '0;
      end else if (load1) begin
         slot_d = SLOT_W'(1);
      end else if (inc) begin
         slot_d = slot_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot    = slot_q;
   assign is_last = (slot_q == SLOT_W'(LANES - 1));

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux8.sv
// -----------------------------------------------------------------------------
// tdm_demux8
// Receive end of the 8:1 TDM path. Rebuilds LANES parallel lane values from a
// serial bit stream and presents them atomically once per complete frame.
//   clk, rst_n  : clock, asynchronous active-low reset
//   din         : serial data bit for the current slot
//   din_valid   : beat qualifier
//   frame_sync  : marks the beat carrying slot 0 (ignored without din_valid)
//   y           : registered lane outputs, bit k = lane k
//   frame_valid : one-cycle pulse, y updated with a new complete frame
//   sync_err    : one-cycle pulse, alignment violation detected
//   locked      : high while aligned (LOCKED)
//   slot        : slot index expected for the next beat
//
// Handshake: valid-only stream, no back-pressure. A beat is any rising edge
// with din_valid=1; din and frame_sync are meaningful only on beats. Cycles
// with din_valid=0 change nothing except dropping the two pulse outputs.
// -----------------------------------------------------------------------------
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter int LANES  = TDM_LANES_DEF,
   localparam int SLOT_W = $clog2(LANES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   input  logic              din_valid,
   input  logic              frame_sync,
   output logic [LANES-1:0]  y,
   output logic              frame_valid,
   output logic              sync_err,
   output logic              locked,
   output logic [SLOT_W-1:0] slot
);

   tdm_state_t        state_q, state_d;
   // The last lane goes straight from din into y, so only LANES-1 bits
   // need to be held while a frame is being assembled.
   logic [LANES-2:0]  shadow_q, shadow_d;
   logic [LANES-1:0]  y_q, y_d;
   logic              frame_valid_q, frame_valid_d;
   logic              sync_err_q, sync_err_d;

   logic              ctr_clr, ctr_load1, ctr_inc;
   logic [SLOT_W-1:0] slot_w;
   logic              is_last_w;

   tdm_slot_ctr #(
      .LANES (LANES)
   ) u_slot_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (ctr_clr),
      .load1   (ctr_load1),
      .inc     (ctr_inc),
      .slot    (slot_w),
      .is_last (is_last_w)
   );

   always_comb begin
      state_d       = state_q;
      shadow_d      = shadow_q;
      y_d           = y_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
      ctr_clr       = 1'b0;
      ctr_load1     = 1'b0;
      ctr_inc       = 1'b0;

      if (din_valid) begin
         unique case (state_q)
            HUNT: begin
               if (frame_sync) begin
                  shadow_d    = '0;
                  shadow_d[0] = din;
                  ctr_load1   = 1'b1;
                  state_d     = LOCKED;
               end
            end

            LOCKED: begin
               if (frame_sync) begin
                  // Any sync beat restarts the frame at slot 0; if it arrives
                  // early the partial frame is dropped and flagged.
                  if (slot_w != '0) begin
                     sync_err_d = 1'b1;
                     shadow_d   = '0;
                  end
                  shadow_d[0] = din;
                  ctr_load1   = 1'b1;
               end else if (slot_w == '0) begin
                  // Slot 0 without sync: alignment lost, beat discarded.
                  sync_err_d = 1'b1;
                  ctr_clr    = 1'b1;
                  state_d    = HUNT;
               end else if (is_last_w) begin
                  y_d           = {din, shadow_q};
                  frame_valid_d = 1'b1;
                  ctr_clr       = 1'b1;
               end else begin
                  for (int k = 1; k < LANES - 1; k++) begin
                     if (slot_w == SLOT_W'(k)) begin
                        shadow_d[k] = din;
                     end
                  end
                  ctr_inc = 1'b1;
               end
            end

            default: begin
               state_d = HUNT;
               ctr_clr = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         shadow_q      <= '0;
         y_q           <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         y_q           <= y_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign y           = y_q;
   assign frame_valid = frame_valid_q;
   assign sync_err    = sync_err_q;
   assign locked      = (state_q == LOCKED);
   assign slot        = slot_w;

endmodule : tdm_demux8

// File: tb/tb_tdm_demux8.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux8
// Directed testbench for tdm_demux8. Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point, i.e. they show the result of
// the edge just taken.
// -----------------------------------------------------------------------------
module tb_tdm_demux8;

   logic       clk;
   logic       rst_n;
   logic       din;
   logic       din_valid;
   logic       frame_sync;
   logic [7:0] y;
   logic       frame_valid;
   logic       sync_err;
   logic       locked;
   logic [2:0] slot;

   int vectors;
   int miscompares;

   tdm_demux8 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .frame_sync  (frame_sync),
      .y           (y),
      .frame_valid (frame_valid),
      .sync_err    (sync_err),
      .locked      (locked),
      .slot        (slot)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic do_beat(input logic d, input logic fs);
      din        = d;
      frame_sync = fs;
      din_valid  = 1'b1;
      @(posedge clk);
      #1;
      din_valid  = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic do_idle(input int n);
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst_n = 1'b0;
      din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (y !== 8'h00) begin miscompares++; $display("FAIL reset_y: got %h expected 00", y); end
      vectors++; if (slot !== 3'd0) begin miscompares++; $display("FAIL reset_slot: got %0d expected 0", slot); end
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b expected 0", locked); end
      vectors++; if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: got fv=%b err=%b expected 0 0", frame_valid, sync_err); end
      rst_n = 1'b1;
      do_idle(1);
   endtask

   task automatic test_hunt_discard;
      for (int i = 0; i < 10; i++) begin
         do_beat(1'b1, 1'b0);
         vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL hunt_locked[%0d]: got %b expected 0", i, locked); end
         vectors++; if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin miscompares++; $display("FAIL hunt_pulses[%0d]: got fv=%b err=%b expected 0 0", i, frame_valid, sync_err); end
      end
      vectors++; if (y !== 8'h00) begin miscompares++; $display("FAIL hunt_y: got %h expected 00", y); end
      vectors++; if (slot !== 3'd0) begin miscompares++; $display("FAIL hunt_slot: got %0d expected 0", slot); end
   endtask

   task automatic test_clean_frames;
      logic [7:0] frames [2];
      logic [7:0] y_prev;
      frames[0] = 8'h01;
      frames[1] = 8'h86;
      y_prev    = 8'h00;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 8; i++) begin
            do_beat(frames[f][i], i == 0);
            vectors++; if (frame_valid !== (i == 7)) begin miscompares++; $display("FAIL clean_fv[%0d][%0d]: got %b expected %b", f, i, frame_valid, (i == 7)); end
            vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL clean_err[%0d][%0d]: got %b expected 0", f, i, sync_err); end
            vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL clean_locked[%0d][%0d]: got %b expected 1", f, i, locked); end
            vectors++; if (slot !== 3'((i + 1) % 8)) begin miscompares++; $display("FAIL clean_slot[%0d][%0d]: got %0d expected %0d", f, i, slot, (i + 1) % 8); end
            if (i < 7) begin
               vectors++; if (y !== y_prev) begin miscompares++; $display("FAIL clean_y_hold[%0d][%0d]: got %h expected %h", f, i, y, y_prev); end
            end
         end
         vectors++; if (y !== frames[f]) begin miscompares++; $display("FAIL clean_y[%0d]: got %h expected %h", f, y, frames[f]); end
         y_prev = frames[f];
      end
      // Pulse lasts exactly one cycle.
      do_idle(1);
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL clean_fv_width: got %b expected 0", frame_valid); end
   endtask

   task automatic test_gapped;
      logic [7:0] bits;
      logic [2:0] slot_gap;
      bits = 8'h01;
      for (int i = 0; i < 8; i++) begin
         do_beat(bits[i], i == 0);
         vectors++; if (frame_valid !== (i == 7)) begin miscompares++; $display("FAIL gap_fv[%0d]: got %b expected %b", i, frame_valid, (i == 7)); end
         if (i == 1 || i == 4) begin
            slot_gap = 3'(i + 1);
            for (int g = 0; g < 3; g++) begin
               do_idle(1);
               vectors++; if (slot !== slot_gap) begin miscompares++; $display("FAIL gap_slot[%0d.%0d]: got %0d expected %0d", i, g, slot, slot_gap); end
               vectors++; if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin miscompares++; $display("FAIL gap_pulses[%0d.%0d]: got fv=%b err=%b expected 0 0", i, g, frame_valid, sync_err); end
            end
         end
      end
      vectors++; if (y !== 8'h01) begin miscompares++; $display("FAIL gap_y: got %h expected 01", y); end
   endtask

   task automatic test_early_sync;
      logic [7:0] bits;
      // Known reference frame so the held value is distinguishable.
      bits = 8'h86;
      for (int i = 0; i < 8; i++) do_beat(bits[i], i == 0);
      vectors++; if (y !== 8'h86) begin miscompares++; $display("FAIL early_ref_y: got %h expected 86", y); end

      // Sync + 4 beats of 1, then a sync on the 6th beat (slot 5).
      for (int i = 0; i < 5; i++) do_beat(1'b1, i == 0);
      do_beat(1'b1, 1'b1);
      vectors++; if (sync_err !== 1'b1) begin miscompares++; $display("FAIL early_err: got %b expected 1", sync_err); end
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL early_fv: got %b expected 0", frame_valid); end
      vectors++; if (y !== 8'h86) begin miscompares++; $display("FAIL early_y_hold: got %h expected 86", y); end
      vectors++; if (locked !== 1'b1 || slot !== 3'd1) begin miscompares++; $display("FAIL early_realign: got locked=%b slot=%0d expected 1 1", locked, slot); end
      for (int i = 1; i < 8; i++) begin
         do_beat(1'b0, 1'b0);
         vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL early_err_width[%0d]: got %b expected 0", i, sync_err); end
      end
      vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL early_new_fv: got %b expected 1", frame_valid); end
      vectors++; if (y !== 8'h01) begin miscompares++; $display("FAIL early_new_y: got %h expected 01", y); end

      // Sync landing on the last slot is also early: no frame, error instead.
      for (int i = 0; i < 7; i++) do_beat(1'b1, i == 0);
      do_beat(1'b0, 1'b1);
      vectors++; if (sync_err !== 1'b1 || frame_valid !== 1'b0) begin miscompares++; $display("FAIL early_last: got err=%b fv=%b expected 1 0", sync_err, frame_valid); end
      vectors++; if (y !== 8'h01) begin miscompares++; $display("FAIL early_last_y: got %h expected 01", y); end
      for (int i = 1; i < 8; i++) do_beat(i == 1 || i == 2 || i == 7, 1'b0);
      vectors++; if (frame_valid !== 1'b1 || y !== 8'h86) begin miscompares++; $display("FAIL early_last_new: got fv=%b y=%h expected 1 86", frame_valid, y); end
   endtask

   task automatic test_missing_sync;
      logic [7:0] bits;
      bits = 8'h01;
      for (int i = 0; i < 8; i++) do_beat(bits[i], i == 0);
      vectors++; if (y !== 8'h01) begin miscompares++; $display("FAIL miss_ref_y: got %h expected 01", y); end
      do_beat(1'b1, 1'b0);
      vectors++; if (sync_err !== 1'b1) begin miscompares++; $display("FAIL miss_err: got %b expected 1", sync_err); end
      vectors++; if (locked !== 1'b0 || slot !== 3'd0) begin miscompares++; $display("FAIL miss_hunt: got locked=%b slot=%0d expected 0 0", locked, slot); end
      for (int i = 0; i < 9; i++) begin
         do_beat(1'b1, 1'b0);
         vectors++; if (sync_err !== 1'b0 || frame_valid !== 1'b0 || locked !== 1'b0) begin miscompares++; $display("FAIL miss_discard[%0d]: got err=%b fv=%b locked=%b expected 0 0 0", i, sync_err, frame_valid, locked); end
      end
      vectors++; if (y !== 8'h01) begin miscompares++; $display("FAIL miss_y_hold: got %h expected 01", y); end
      bits = 8'h86;
      do_beat(bits[0], 1'b1);
      vectors++; if (locked !== 1'b1 || slot !== 3'd1) begin miscompares++; $display("FAIL miss_relock: got locked=%b slot=%0d expected 1 1", locked, slot); end
      for (int i = 1; i < 8; i++) do_beat(bits[i], 1'b0);
      vectors++; if (frame_valid !== 1'b1 || y !== 8'h86) begin miscompares++; $display("FAIL miss_relock_frame: got fv=%b y=%h expected 1 86", frame_valid, y); end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] bits;
      for (int i = 0; i < 4; i++) do_beat(1'b1, i == 0);
      vectors++; if (slot !== 3'd4 || y !== 8'h86) begin miscompares++; $display("FAIL rstmid_pre: got slot=%0d y=%h expected 4 86", slot, y); end
      rst_n = 1'b0;
      #2;
      vectors++; if (y !== 8'h00) begin miscompares++; $display("FAIL rstmid_y: got %h expected 00", y); end
      vectors++; if (slot !== 3'd0) begin miscompares++; $display("FAIL rstmid_slot: got %0d expected 0", slot); end
      vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rstmid_locked: got %b expected 0", locked); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // Leftover beats of the interrupted frame must not complete anything.
      for (int i = 0; i < 4; i++) begin
         do_beat(1'b1, 1'b0);
         vectors++; if (frame_valid !== 1'b0 || locked !== 1'b0) begin miscompares++; $display("FAIL rstmid_tail[%0d]: got fv=%b locked=%b expected 0 0", i, frame_valid, locked); end
      end
      bits = 8'h01;
      for (int i = 0; i < 8; i++) begin
         do_beat(bits[i], i == 0);
         vectors++; if (frame_valid !== (i == 7)) begin miscompares++; $display("FAIL rstmid_fv[%0d]: got %b expected %b", i, frame_valid, (i == 7)); end
      end
      vectors++; if (y !== 8'h01) begin miscompares++; $display("FAIL rstmid_new_y: got %h expected 01", y); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset;
      test_hunt_discard;
      test_clean_frames;
      test_gapped;
      test_early_sync;
      test_missing_sync;
      test_reset_mid_frame;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_tdm_demux8
